// File: rtl/result_pack_write.sv
// rtl/result_pack_write.sv - packs four DATA_W results into one SRAM word and writes it
module result_pack_write #(
    parameter int DATA_W = 48,
    parameter int ADDR_W = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  put_value_flag,
    input  logic [DATA_W-1:0]     value_in,
    output logic                  put_ready,
    input  logic                  flush,
    input  logic [ADDR_W-1:0]     last_address,
    output logic                  write_enable,
    output logic [ADDR_W-1:0]     write_address,
    output logic [4*DATA_W-1:0]   write_data,
    output logic [2:0]            fill_level,
    output logic                  done
);

    typedef enum logic {FILL, WRITE} state_t;

    state_t                state;
    state_t                state_next;
    logic [1:0]            fill_cnt;
    logic [4*DATA_W-1:0]   pack;
    logic [4*DATA_W-1:0]   pack_next;
    logic                  accept;
    logic                  go_write;

    assign fill_level = {1'b0, fill_cnt};

    always_comb begin
        accept       = 1'b0;
        go_write     = 1'b0;
        pack_next    = pack;
        state_next   = state;
        put_ready    = 1'b0;
        write_enable = 1'b0;
        done         = 1'b0;
        case (state)
            FILL: begin
                put_ready = 1'b1;
                accept    = enable && put_value_flag;
                // First value lands in the most significant slot.
                if (accept) begin
                    case (fill_cnt)
                        2'd0:    pack_next[4*DATA_W-1 -: DATA_W] = value_in;
                        2'd1:    pack_next[3*DATA_W-1 -: DATA_W] = value_in;
                        2'd2:    pack_next[2*DATA_W-1 -: DATA_W] = value_in;
                        default: pack_next[DATA_W-1   -: DATA_W] = value_in;
                    endcase
                end
                go_write = (accept && fill_cnt == 2'd3) ||
                           (enable && flush && (fill_cnt != 2'd0 || accept));
                if (go_write) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                write_enable = 1'b1;
                done         = (write_address == last_address);
                state_next   = FILL;
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= FILL;
            fill_cnt      <= 2'd0;
            pack          <= '0;
            write_address <= '0;
            write_data    <= '0;
        end else begin
            state <= state_next;
            if (go_write) begin
                write_data <= pack_next;
                pack       <= '0;
                fill_cnt   <= 2'd0;
            end else if (accept) begin
                pack     <= pack_next;
                fill_cnt <= fill_cnt + 2'd1;
            end
            if (state == WRITE) begin
                write_address <= done ? '0 : write_address + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_result_pack_write.sv
// tb/tb_result_pack_write.sv - scoreboard bench for result_pack_write
module tb_result_pack_write;

    localparam int DATA_W = 48;
    localparam int ADDR_W = 8;

    typedef struct packed {
        logic                done;
        logic [ADDR_W-1:0]   addr;
        logic [4*DATA_W-1:0] data;
    } wr_t;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                enable = 1'b0;
    logic                put_value_flag = 1'b0;
    logic [DATA_W-1:0]   value_in = '0;
    logic                put_ready;
    logic                flush = 1'b0;
    logic [ADDR_W-1:0]   last_address = 8'd255;
    logic                write_enable;
    logic [ADDR_W-1:0]   write_address;
    logic [4*DATA_W-1:0] write_data;
    logic [2:0]          fill_level;
    logic                done;

    int total = 0;
    int bad = 0;
    int writes_seen = 0;
    int writes_exp = 0;

    wr_t               exp_q[$];
    logic [DATA_W-1:0] mvals[$];
    logic [ADDR_W-1:0] maddr = '0;

    result_pack_write #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .put_value_flag(put_value_flag), .value_in(value_in), .put_ready(put_ready),
        .flush(flush), .last_address(last_address), .write_enable(write_enable),
        .write_address(write_address), .write_data(write_data),
        .fill_level(fill_level), .done(done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push_word();
        wr_t w;
        w.data = '0;
        for (int i = 0; i < mvals.size(); i++)
            w.data[(4-i)*DATA_W-1 -: DATA_W] = mvals[i];
        w.addr = maddr;
        w.done = (maddr == last_address);
        maddr  = w.done ? '0 : maddr + 8'd1;
        exp_q.push_back(w);
        writes_exp++;
        mvals.delete();
    endtask

    // Offer v, holding it until the block accepts; returns #1 after the accepting edge.
    task automatic put(input logic [DATA_W-1:0] v, input logic with_flush);
        int budget;
        budget = 0;
        put_value_flag = 1'b1;
        value_in = v;
        while (!put_ready && budget < 20) begin
            @(posedge clock); #1;
            budget++;
        end
        check("put_wait_timeout", budget < 20, 1'b1);
        flush = with_flush;
        @(posedge clock); #1;
        flush = 1'b0;
        mvals.push_back(v);
        if (mvals.size() == 4 || with_flush) push_word();
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        if (mvals.size() != 0) push_word();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        maddr = '0;
        mvals.delete();
    endtask

    task automatic idle(input int n);
        put_value_flag = 1'b0;
        repeat (n) begin
            @(posedge clock); #1;
        end
    endtask

    always @(negedge clock) begin
        if (write_enable) begin
            writes_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 1'b1, 1'b0);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check("wr_data", write_data, w.data);
                check("wr_addr", write_address, w.addr);
                check("wr_done", done, w.done);
            end
        end else if (done) begin
            check("done_without_write", done, 1'b0);
        end
    end

    initial begin
        @(posedge clock); #1;
        do_reset();
        check("rst_we", write_enable, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_addr", write_address, 8'd0);
        check("rst_data", write_data, 192'd0);
        check("rst_fill", fill_level, 3'd0);
        check("rst_ready", put_ready, 1'b1);
        enable = 1'b1;

        // Four back-to-back accepts.
        put(48'hA0000000000A, 1'b0);
        check("fill_1", fill_level, 3'd1);
        put(48'hB0000000000B, 1'b0);
        put(48'hC0000000000C, 1'b0);
        put(48'hD0000000000D, 1'b0);
        put_value_flag = 1'b0;
        check("b2b_we", write_enable, 1'b1);
        check("b2b_ready", put_ready, 1'b0);
        check("b2b_addr", write_address, 8'd0);
        check("b2b_fill", fill_level, 3'd0);
        idle(1);
        check("b2b_ready_after", put_ready, 1'b1);
        check("b2b_addr_after", write_address, 8'd1);
        check("b2b_hold", write_data, {48'hA0000000000A, 48'hB0000000000B, 48'hC0000000000C, 48'hD0000000000D});

        // Two accepts then flush.
        put(48'h111111111111, 1'b0);
        put(48'h222222222222, 1'b0);
        put_value_flag = 1'b0;
        check("fill_2", fill_level, 3'd2);
        do_flush();
        check("flush_fill", fill_level, 3'd0);
        idle(1);

        // Flush with nothing pending is ignored.
        do_flush();
        check("empty_flush_we", write_enable, 1'b0);

        // Flush together with an accept packs the value first.
        put(48'h333333333333, 1'b0);
        put(48'h444444444444, 1'b1);
        put_value_flag = 1'b0;
        idle(1);

        // enable low: puts and flush ignored.
        put(48'h555555555555, 1'b0);
        enable = 1'b0;
        put_value_flag = 1'b1;
        value_in = 48'hDEADDEADDEAD;
        flush = 1'b1;
        repeat (3) begin
            @(posedge clock); #1;
        end
        flush = 1'b0;
        check("en0_fill", fill_level, 3'd1);
        check("en0_we", write_enable, 1'b0);
        put_value_flag = 1'b0;
        enable = 1'b1;
        do_flush();
        idle(1);

        // Wrap at last_address=2 with held put_value_flag.
        do_reset();
        last_address = 8'd2;
        for (int i = 0; i < 12; i++)
            put(48'h0F0000000000 + DATA_W'(i), 1'b0);
        put(48'h0F00000000FF, 1'b1);
        put_value_flag = 1'b0;
        idle(2);

        // Held values over random data: 8 values -> 2 words.
        for (int i = 0; i < 8; i++)
            put({$urandom(), 16'(i)}, 1'b0);
        put_value_flag = 1'b0;
        idle(2);

        // Reset during the WRITE cycle drops the pending address advance.
        for (int i = 0; i < 4; i++)
            put(48'h777700000000 + DATA_W'(i), 1'b0);
        put_value_flag = 1'b0;
        check("pre_rst_we", write_enable, 1'b1);
        do_reset();
        check("midrst_we", write_enable, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_addr", write_address, 8'd0);
        check("midrst_data", write_data, 192'd0);
        check("midrst_fill", fill_level, 3'd0);
        check("midrst_ready", put_ready, 1'b1);
        idle(3);

        check("queue_drained", exp_q.size(), 0);
        check("write_count", writes_seen, writes_exp);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
